cifra_mistura_colunas: RTL and testbench

Sequential MixColumns engine for the encrypt path of the AES core. It accepts one 128-bit state over a valid/ready handshake and processes one column per cycle: each output byte is 02·a ⊕ 03·b ⊕ c ⊕ d over GF(2^8), reduced mod x^8+x^4+x^3+x+1. It returns the mixed state over a second valid/ready handshake. A bypass input serves the final cipher round, which skips MixColumns.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/mistura_coluna.sv | 33 +++
 rtl/cifra_mistura_colunas.sv | 114 +++++++++++
 tb/tb_cifra_mistura_colunas.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the encrypt datapath.
//   AES_POLI_RED  : low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
//   AES_N_COLUNAS : number of 32-bit columns in a 128-bit state
//   estado_t      : control states of the MixColumns engine
//   byte_lsb / coluna_ler / coluna_escrever : byte and column addressing helpers.
//     Byte k of a state sits at bits [127-8k -: 8]; column c is bytes
//     {c, c+4, c+8, c+12}, top row in bits [31:24] of the column word.
package aes_pkg;

  localparam logic [7:0] AES_POLI_RED  = 8'h1B;
  localparam int         AES_N_COLUNAS = 4;

  typedef enum logic [1:0] {
    OCIOSO,
    CALCULA,
    PRONTO
  } estado_t;

  // Lowest bit index of byte k inside a 128-bit state.
  function automatic int byte_lsb(input int k);
    return 120 - 8 * k;
  endfunction

  function automatic logic [31:0] coluna_ler(input logic [127:0] s, input logic [1:0] c);
    logic [31:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      r[24 - 8 * row +: 8] = s[byte_lsb(int'(c) + 4 * row) +: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] coluna_escrever(input logic [127:0] s, input logic [1:0] c,
                                                   input logic [31:0] v);
    logic [127:0] r;
    r = s;
    for (int row = 0; row < 4; row++) begin
      r[byte_lsb(int'(c) + 4 * row) +: 8] = v[24 - 8 * row +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mistura_coluna.sv
// Combinational MixColumns on a single column.
//   coluna  in  32  column {a,b,c,d}, a in bits [31:24]
//   mistura out 32  mixed column, same layout
// Only four xtime units are needed: 3x is formed as xtime(x) ^ x.
module mistura_coluna (
  input  logic [31:0] coluna,
  output logic [31:0] mistura
);
  import aes_pkg::*;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLI_RED : 8'h00);
  endfunction

  logic [7:0] a, b, c, d;
  logic [7:0] a2, b2, c2, d2;

  always_comb begin
    a  = coluna[31:24];
    b  = coluna[23:16];
    c  = coluna[15:8];
    d  = coluna[7:0];
    a2 = xtime(a);
    b2 = xtime(b);
    c2 = xtime(c);
    d2 = xtime(d);
    mistura[31:24] = a2 ^ (b2 ^ b) ^ c ^ d;
    mistura[23:16] = a ^ b2 ^ (c2 ^ c) ^ d;
    mistura[15:8]  = a ^ b ^ c2 ^ (d2 ^ d);
    mistura[7:0]   = (a2 ^ a) ^ b ^ c ^ d2;
  end

endmodule

// File: rtl/cifra_mistura_colunas.sv
// Sequential MixColumns engine: one column per cycle, valid/ready on both sides.
//   clk         in   1    clock
//   rst         in   1    synchronous active-high reset
//   ent_valid   in   1    bloco/bypass valid
//   ent_ready   out  1    engine can take a state this cycle
//   bloco       in   128  input state
//   bypass      in   1    1 = return bloco unmixed (final round)
//   saida_valid out  1    saida holds a result
//   saida_ready in   1    consumer accepts saida
//   saida       out  128  result state
module cifra_mistura_colunas (
  input  logic         clk,
  input  logic         rst,
  input  logic         ent_valid,
  output logic         ent_ready,
  input  logic [127:0] bloco,
  input  logic         bypass,
  output logic         saida_valid,
  input  logic         saida_ready,
  output logic [127:0] saida
);
  import aes_pkg::*;

  estado_t        state_reg, state_next;
  logic [1:0]     col_reg, col_next;
  logic [127:0]   work_reg, work_next;
  logic [127:0]   saida_reg, saida_next;
  logic           captura;
  logic [31:0]    coluna_atual, mistura;
  logic [AES_N_COLUNAS-1:0] col_en;

  // Single shared column mixer, fed by the column selected by col_reg.
  assign coluna_atual = coluna_ler(work_reg, col_reg);

  mistura_coluna u_mistura (
    .coluna  (coluna_atual),
    .mistura (mistura)
  );

  // One write enable per output column, active only in its CALCULA slot.
  for (genvar gi = 0; gi < AES_N_COLUNAS; gi++) begin : g_col_en
    assign col_en[gi] = (state_reg == CALCULA) && (col_reg == 2'(gi));
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    ent_ready  = 1'b0;
    captura    = 1'b0;
    case (state_reg)
      OCIOSO: begin
        ent_ready = 1'b1;
        if (ent_valid) begin
          captura    = 1'b1;
          state_next = bypass ? PRONTO : CALCULA;
          col_next   = 2'd0;
        end
      end
      CALCULA: begin
        col_next = col_reg + 2'd1;
        if (col_reg == 2'd3) begin
          state_next = PRONTO;
        end
      end
      PRONTO: begin
        // Releasing the result frees the engine, so a new state may be
        // taken in the very same cycle.
        ent_ready = saida_ready;
        if (saida_ready) begin
          if (ent_valid) begin
            captura    = 1'b1;
            state_next = bypass ? PRONTO : CALCULA;
            col_next   = 2'd0;
          end else begin
            state_next = OCIOSO;
          end
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_comb begin
    work_next  = captura ? bloco : work_reg;
    saida_next = saida_reg;
    if (captura && bypass) begin
      saida_next = bloco;
    end else begin
      for (int c = 0; c < AES_N_COLUNAS; c++) begin
        if (col_en[c]) begin
          saida_next = coluna_escrever(saida_next, 2'(c), mistura);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= OCIOSO;
      col_reg   <= 2'd0;
      work_reg  <= '0;
      saida_reg <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      work_reg  <= work_next;
      saida_reg <= saida_next;
    end
  end

  assign saida_valid = (state_reg == PRONTO);
  assign saida       = saida_reg;

endmodule

// File: tb/tb_cifra_mistura_colunas.sv
module tb_cifra_mistura_colunas;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ent_valid = 1'b0;
  logic         ent_ready;
  logic [127:0] bloco = '0;
  logic         bypass = 1'b0;
  logic         saida_valid;
  logic         saida_ready = 1'b0;
  logic [127:0] saida;

  int           ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int           errors = 0;
  int           checks = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  cifra_mistura_colunas dut (
    .clk         (clk),
    .rst         (rst),
    .ent_valid   (ent_valid),
    .ent_ready   (ent_ready),
    .bloco       (bloco),
    .bypass      (bypass),
    .saida_valid (saida_valid),
    .saida_ready (saida_ready),
    .saida       (saida)
  );

  // Consumer: updates at posedge+2 so a mode change made at posedge+1 applies this cycle.
  always begin
    @(posedge clk);
    #2;
    if (ready_mode == 2) saida_ready = 1'($urandom_range(0, 1));
    else                 saida_ready = (ready_mode == 1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // Place four columns {top..bottom} into the byte layout c + 4*row.
  function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    logic [127:0] s;
    logic [31:0]  cols[4];
    cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[120 - 8 * (c + 4 * r) +: 8] = cols[c][24 - 8 * r +: 8];
    return s;
  endfunction

  // Generic shift-and-add GF(2^8) multiply for the random reference.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a;
    p = 8'h00; a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   acc, coef;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          coef = (((j - r + 4) % 4) == 0) ? 8'd2 : ((((j - r + 4) % 4) == 1) ? 8'd3 : 8'd1);
          acc = acc ^ gmul(coef, s[120 - 8 * (c + 4 * j) +: 8]);
        end
        o[120 - 8 * (c + 4 * r) +: 8] = acc;
      end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("check %s ok: %h", name, act);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
  task automatic send(input logic [127:0] b, input logic byp, input logic [127:0] e, input bit push);
    int n;
    n = 0;
    ent_valid = 1'b1; bloco = b; bypass = byp;
    @(negedge clk);
    while (!ent_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ent_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got ent_ready=0 required 1");
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ent_valid = 1'b0; bloco = ~b; bypass = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  logic [127:0] v1, v1_exp, v2, v2_exp, s0, rb;
  int           lat;

  initial begin
    v1     = mk(32'hdb135345, 32'h0, 32'h0, 32'h0);
    v1_exp = mk(32'h8e4da1bc, 32'h0, 32'h0, 32'h0);
    v2     = mk(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5);
    v2_exp = mk(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6);

    fork
      begin : monitor
        logic [127:0] e;
        forever begin
          @(negedge clk);
          if (saida_valid && saida_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL saida_extra: got %h required no output", saida);
            end else begin
              e = exp_q.pop_front();
              if (saida !== e) begin
                errors++;
                $display("FAIL saida: got %h required %h", saida, e);
              end else begin
                $display("saida %h ok", saida);
              end
            end
          end
        end
      end
      begin : driver
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ent_ready", 128'(ent_ready), 128'd1);
        chk("rst_saida_valid", 128'(saida_valid), 128'd0);
        chk("rst_saida", saida, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single column, latency 5
        ready_mode = 1;
        send(v1, 1'b0, v1_exp, 1'b1);
        lat = 1;
        @(negedge clk);
        while (!saida_valid && lat < 50) begin
          @(negedge clk);
          lat++;
        end
        chk("latency_normal", 128'(lat), 128'd5);
        drain();

        // Four columns
        send(v2, 1'b0, v2_exp, 1'b1);
        drain();

        // Bypass with consumer not ready: result at t+1, ent_ready low
        ready_mode = 0;
        send(v2, 1'b1, v2, 1'b1);
        @(negedge clk);
        chk("bypass_valid_t1", 128'(saida_valid), 128'd1);
        chk("bypass_saida", saida, v2);
        chk("bypass_ent_ready", 128'(ent_ready), 128'd0);
        @(posedge clk); #1;
        ready_mode = 1;
        @(negedge clk);
        chk("bypass_ent_ready_rdy", 128'(ent_ready), 128'd1);
        @(posedge clk); #1;
        drain();

        // Backpressure: hold result 10 cycles with a new input pending
        ready_mode = 0;
        send(v1, 1'b0, v1_exp, 1'b1);
        lat = 0;
        @(negedge clk);
        while (!saida_valid && lat < 50) begin
          @(negedge clk);
          lat++;
        end
        s0 = saida;
        chk("bp_hold_value", s0, v1_exp);
        @(posedge clk); #1;
        ent_valid = 1'b1; bloco = v2; bypass = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_saida_stable", saida, s0);
          chk("bp_ent_ready_low", 128'(ent_ready), 128'd0);
          @(posedge clk); #1;
        end
        ready_mode = 1;
        @(negedge clk);
        chk("bp_capture_ready", 128'(ent_ready), 128'd1);
        exp_q.push_back(v2_exp);
        @(posedge clk); #1;
        ent_valid = 1'b0; bloco = '0;
        @(negedge clk);
        chk("bp_now_calcula", 128'(ent_ready), 128'd0);
        @(posedge clk); #1;
        drain();

        // Reset on the second CALCULA cycle
        send(v2, 1'b0, v2_exp, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_saida", saida, 128'd0);
        chk("midrst_saida_valid", 128'(saida_valid), 128'd0);
        chk("midrst_ent_ready", 128'(ent_ready), 128'd1);
        @(posedge clk); #1;
        send(v1, 1'b0, v1_exp, 1'b1);
        drain();

        // Random states with random valid gaps and consumer readiness
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
          logic byp;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          rb  = {$urandom, $urandom, $urandom, $urandom};
          byp = ($urandom_range(0, 3) == 0);
          send(rb, byp, byp ? rb : ref_mix(rb), 1'b1);
        end
        ready_mode = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

endmodule
